// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state encodings, requester IDs and widths for the memory port arbiter
package mem_port_arbiter_pkg;
  localparam int ADDR_W = 32;
  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_LS = 1'b1;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } arb_state_e;
  function automatic arb_state_e busy_of(input logic id);
    return (id == REQ_LS) ? BUSY1 : BUSY0;
  endfunction
endpackage

// File: rtl/mem_port_arbiter_mux.sv
// mem_port_arbiter_mux: 2-to-1 word mux, out = sel ? a : b
module mem_port_arbiter_mux #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sel_i,
  output logic [W-1:0] out_o
);
  assign out_o = sel_i ? a_i : b_i;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin owner of the shared memory address port, held until ack or watchdog release
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic              req1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic              mem_ack_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic              sel_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              timeout_o
);
  arb_state_e       state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d, sel_q, sel_d, to_q, to_d;
  logic             busy, owner, own_req, oth_req, wd_hit;
  assign busy    = (state_q == BUSY0) || (state_q == BUSY1);
  assign owner   = state_q == BUSY1;
  assign own_req = owner ? req1_i : req0_i;
  assign oth_req = owner ? req0_i : req1_i;
  assign wd_hit  = cnt_q == CNT_W'(TIMEOUT);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      last_q  <= REQ_LS;
      cnt_q   <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      sel_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      sel_q   <= sel_d;
      to_q    <= to_d;
    end
  end
  // ack outranks abort, which outranks the watchdog; the pulse only fires on a true watchdog release
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    to_d    = 1'b0;
    if (!busy)
      state_d = (req0_i && req1_i) ? busy_of(!last_q) : req0_i ? BUSY0 : req1_i ? BUSY1 : IDLE;
    else if (mem_ack_i) begin
      last_d  = owner;
      state_d = oth_req ? busy_of(!owner) : IDLE;
    end else if (!own_req || wd_hit) begin
      last_d  = owner;
      state_d = IDLE;
      to_d    = own_req;
    end
    cnt_d = (busy && state_d == state_q) ? cnt_q + CNT_W'(1) : '0;
  end
  always_comb begin
    gnt0_d = state_d == BUSY0;
    gnt1_d = state_d == BUSY1;
    sel_d  = gnt1_d ? 1'b1 : gnt0_d ? 1'b0 : sel_q;
  end
  assign gnt0_o    = gnt0_q;
  assign gnt1_o    = gnt1_q;
  assign sel_o     = sel_q;
  assign mem_req_o = gnt0_q | gnt1_q;
  assign timeout_o = to_q;
  mem_port_arbiter_mux #(.W(ADDR_W)) u_mux (
    .a_i  (addr1_i),
    .b_i  (addr0_i),
    .sel_i(sel_q),
    .out_o(mem_addr_o)
  );
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(gnt0_q && gnt1_q));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic against a requester-level reference model
module tb_mem_port_arbiter;
  localparam int TIMEOUT = 15;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req0_i = 1'b0, req1_i = 1'b0, mem_ack_i = 1'b0;
  logic [31:0] addr0_i = '0, addr1_i = '0;
  logic        gnt0_o, gnt1_o, sel_o, mem_req_o, timeout_o;
  logic [31:0] mem_addr_o;
  int          tests = 0;
  int          fails = 0;
  wire  [4:0]  obs = {gnt0_o, gnt1_o, sel_o, mem_req_o, timeout_o};

  mem_port_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req0_i(req0_i), .addr0_i(addr0_i),
    .req1_i(req1_i), .addr1_i(addr1_i), .mem_ack_i(mem_ack_i),
    .gnt0_o(gnt0_o), .gnt1_o(gnt1_o), .sel_o(sel_o), .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  task automatic do_reset();
    rst_ni = 1'b0; req0_i = 1'b0; req1_i = 1'b0; mem_ack_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic cyc();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // obs bit order: gnt0 gnt1 sel mem_req timeout
  task automatic test_reset();
    rst_ni = 1'b0; req0_i = 1'b1; req1_i = 1'b1; addr0_i = 32'hDEAD_BEEF; addr1_i = 32'h1234_5678;
    repeat (3) @(negedge clk_i);
    tests++; if (obs !== 5'b00000) begin fails++; $display("FAIL reset_outputs got=%b exp=%b", obs, 5'b00000); end
    tests++; if (mem_addr_o !== 32'hDEAD_BEEF) begin fails++; $display("FAIL reset_addr got=%h exp=%h", mem_addr_o, 32'hDEAD_BEEF); end
    req0_i = 1'b0; req1_i = 1'b0;
    rst_ni = 1'b1;
    cyc();
    tests++; if (obs !== 5'b00000) begin fails++; $display("FAIL reset_idle got=%b exp=%b", obs, 5'b00000); end
  endtask

  task automatic test_single();
    do_reset();
    req0_i = 1'b1; addr0_i = 32'h0000_0040; addr1_i = 32'hFFFF_0000;
    cyc();
    tests++; if (obs !== 5'b10010) begin fails++; $display("FAIL single_grant got=%b exp=%b", obs, 5'b10010); end
    tests++; if (mem_addr_o !== 32'h0000_0040) begin fails++; $display("FAIL single_addr got=%h exp=%h", mem_addr_o, 32'h40); end
    cyc();
    mem_ack_i = 1'b1;
    cyc();
    mem_ack_i = 1'b0; req0_i = 1'b0;
    tests++; if (obs !== 5'b00000) begin fails++; $display("FAIL single_release got=%b exp=%b", obs, 5'b00000); end
  endtask

  task automatic test_tie_handover();
    do_reset();
    req0_i = 1'b1; req1_i = 1'b1; addr0_i = 32'h0000_0040; addr1_i = 32'h1000_0000;
    cyc();
    tests++; if (obs !== 5'b10010) begin fails++; $display("FAIL tie_first got=%b exp=%b", obs, 5'b10010); end
    mem_ack_i = 1'b1;
    cyc();
    mem_ack_i = 1'b0; req0_i = 1'b0;
    tests++; if (obs !== 5'b01110) begin fails++; $display("FAIL tie_handover got=%b exp=%b", obs, 5'b01110); end
    tests++; if (mem_addr_o !== 32'h1000_0000) begin fails++; $display("FAIL tie_addr1 got=%h exp=%h", mem_addr_o, 32'h1000_0000); end
    mem_ack_i = 1'b1;
    cyc();
    mem_ack_i = 1'b0; req1_i = 1'b0;
    tests++; if (obs !== 5'b00100) begin fails++; $display("FAIL tie_release got=%b exp=%b", obs, 5'b00100); end
    req0_i = 1'b1; req1_i = 1'b1;
    cyc();
    tests++; if (obs !== 5'b10010) begin fails++; $display("FAIL tie_next_round got=%b exp=%b", obs, 5'b10010); end
    mem_ack_i = 1'b1;
    cyc();
    req0_i = 1'b0;
    cyc();
    mem_ack_i = 1'b0; req1_i = 1'b0;
    tests++; if (obs !== 5'b00100) begin fails++; $display("FAIL tie_drain got=%b exp=%b", obs, 5'b00100); end
  endtask

  task automatic test_timeout();
    int n = 0, tcnt = 0;
    bit seen = 0, dropped = 0;
    do_reset();
    req1_i = 1'b1; addr1_i = 32'h2000_0000;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (gnt1_o) begin n++; seen = 1; end
      if (timeout_o) tcnt++;
      if (seen && !gnt1_o) begin req1_i = 1'b0; dropped = 1; break; end
    end
    tests++; if (!dropped) begin fails++; $display("FAIL timeout_release got=none exp=drop within 40 cycles"); end
    tests++; if (n != TIMEOUT + 1) begin fails++; $display("FAIL timeout_len got=%0d exp=%0d", n, TIMEOUT + 1); end
    tests++; if (obs !== 5'b00101) begin fails++; $display("FAIL timeout_pulse got=%b exp=%b", obs, 5'b00101); end
    cyc();
    tests++; if (obs !== 5'b00100) begin fails++; $display("FAIL timeout_one_cycle got=%b exp=%b", obs, 5'b00100); end
    tests++; if (tcnt != 1) begin fails++; $display("FAIL timeout_count got=%0d exp=1", tcnt); end
    req0_i = 1'b1; req1_i = 1'b1;
    cyc();
    tests++; if (obs !== 5'b10010) begin fails++; $display("FAIL timeout_next_tie got=%b exp=%b", obs, 5'b10010); end
  endtask

  task automatic test_ack_at_timeout();
    do_reset();
    req1_i = 1'b1;
    cyc();
    repeat (TIMEOUT) cyc();
    tests++; if (obs !== 5'b01110) begin fails++; $display("FAIL ackto_held got=%b exp=%b", obs, 5'b01110); end
    mem_ack_i = 1'b1;
    cyc();
    mem_ack_i = 1'b0; req1_i = 1'b0;
    tests++; if (obs !== 5'b00100) begin fails++; $display("FAIL ackto_release got=%b exp=%b", obs, 5'b00100); end
    cyc();
    tests++; if (obs !== 5'b00100) begin fails++; $display("FAIL ackto_no_pulse got=%b exp=%b", obs, 5'b00100); end
  endtask

  task automatic test_abort();
    do_reset();
    req0_i = 1'b1; addr0_i = 32'h0000_0080; addr1_i = 32'h3000_0004;
    cyc();
    tests++; if (obs !== 5'b10010) begin fails++; $display("FAIL abort_grant got=%b exp=%b", obs, 5'b10010); end
    req1_i = 1'b1;
    cyc();
    req0_i = 1'b0;
    cyc();
    tests++; if (obs !== 5'b00000) begin fails++; $display("FAIL abort_idle got=%b exp=%b", obs, 5'b00000); end
    cyc();
    tests++; if (obs !== 5'b01110) begin fails++; $display("FAIL abort_other got=%b exp=%b", obs, 5'b01110); end
    tests++; if (mem_addr_o !== 32'h3000_0004) begin fails++; $display("FAIL abort_addr got=%h exp=%h", mem_addr_o, 32'h3000_0004); end
    mem_ack_i = 1'b1;
    cyc();
    mem_ack_i = 1'b0; req1_i = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    req1_i = 1'b1; addr0_i = 32'h0000_0100; addr1_i = 32'h4000_0000;
    cyc();
    tests++; if (obs !== 5'b01110) begin fails++; $display("FAIL arst_busy got=%b exp=%b", obs, 5'b01110); end
    #2 rst_ni = 1'b0;
    #1;
    tests++; if (obs !== 5'b00000) begin fails++; $display("FAIL arst_immediate got=%b exp=%b", obs, 5'b00000); end
    tests++; if (mem_addr_o !== 32'h0000_0100) begin fails++; $display("FAIL arst_addr got=%h exp=%h", mem_addr_o, 32'h100); end
    req0_i = 1'b1;
    @(negedge clk_i);
    rst_ni = 1'b1;
    tests++; if (obs !== 5'b00000) begin fails++; $display("FAIL arst_held got=%b exp=%b", obs, 5'b00000); end
    cyc();
    tests++; if (obs !== 5'b10010) begin fails++; $display("FAIL arst_first got=%b exp=%b", obs, 5'b10010); end
    req0_i = 1'b0; req1_i = 1'b0;
    cyc();
  endtask

  // Reference: who owns the port, how many edges it has held it, and who was served last.
  task automatic test_random();
    int own = -1, last = 1, held = 0;
    bit esel = 0, eto = 0, ack = 0;
    bit r[2] = '{0, 0};
    bit served[2] = '{0, 0};
    logic [31:0] a[2] = '{32'h0, 32'h0};
    logic [4:0] exp;
    logic [31:0] eaddr;
    do_reset();
    addr0_i = 32'h0; addr1_i = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (r[i] && served[i]) r[i] = 0;
        else if (!r[i] && $urandom_range(3) == 0) begin r[i] = 1; a[i] = $urandom; end
        else if (r[i] && own == i && $urandom_range(39) == 0) r[i] = 0;
        served[i] = 0;
      end
      ack = ((c / 200) % 2 == 0) ? ($urandom_range(2) == 0) : ($urandom_range(60) == 0);
      req0_i = r[0]; req1_i = r[1]; addr0_i = a[0]; addr1_i = a[1]; mem_ack_i = ack;
      @(posedge clk_i);
      eto = 0;
      if (own < 0) begin
        if (r[0] && r[1]) own = 1 - last;
        else if (r[0]) own = 0;
        else if (r[1]) own = 1;
        held = 0;
      end else if (ack) begin
        served[own] = 1; last = own; own = r[1 - own] ? 1 - own : -1; held = 0;
      end else if (!r[own]) begin
        last = own; own = -1;
      end else if (held == TIMEOUT) begin
        served[own] = 1; last = own; own = -1; eto = 1;
      end else held++;
      if (own >= 0) esel = own[0];
      @(negedge clk_i);
      exp = {own == 0, own == 1, esel, own >= 0, eto};
      eaddr = esel ? a[1] : a[0];
      tests++; if (obs !== exp) begin fails++; $display("FAIL rand_ctrl cyc=%0d got=%b exp=%b", c, obs, exp); end
      tests++; if (mem_addr_o !== eaddr) begin fails++; $display("FAIL rand_addr cyc=%0d got=%h exp=%h", c, mem_addr_o, eaddr); end
    end
    req0_i = 1'b0; req1_i = 1'b0; mem_ack_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie_handover();
    test_timeout();
    test_ack_at_timeout();
    test_abort();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
